pll_phase_sequencer: RTL
========================

Name: pll_phase_sequencer

Overview:
- Controller that sits beside the system EHXPLLL instance (25 MHz in; 50 MHz system, 100 MHz SDRAM and 100 MHz/180° SDRAM-controller clocks out).
- Qualifies the PLL lock, produces a synchronous downstream reset, and sequences the dynamic phase-shift pins (PHASESEL/PHASEDIR/PHASESTEP).
- The SDRAM capture phase can then be trimmed at run time by a requester, e.g. a calibration routine or CPU register port.
- Runs on the PLL-independent 25 MHz reference clock.

Parameters:
LOCK_FILTER, 16, consecutive synced-high lock cycles required before the PLL is declared ready
SETUP_CYCLES, 2, cycles phasesel/phasedir are held stable before the first step pulse
STEP_LOW_CYCLES, 4, cycles phasestep is driven low per step
STEP_HIGH_CYCLES, 4, cycles phasestep is driven high after each low phase
SETTLE_CYCLES, 16, cycles waited after the last step before completion
COUNT_W, 8, width of the step-count field

Ports:
clock  in  1  25 MHz reference clock
reset  in  1  synchronous, active-high
pll_locked  in  1  raw PLL LOCK, asynchronous to clock
req_valid  in  1  phase-shift request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_sel  in  2  target output: 0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3
req_dir  in  1  1 = advance, 0 = retard (drives phasedir)
req_count  in  COUNT_W  number of phase steps
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: request aborted by lock loss
busy  out  1  high from accept until done/err
pll_ready  out  1  filtered lock status
sys_rst  out  1  synchronous reset for downstream logic, high while not pll_ready
phasesel  out  2  to PLL PHASESEL[1:0]
phasedir  out  1  to PLL PHASEDIR
phasestep  out  1  to PLL PHASESTEP, idle high

Behaviour:
- Reset values: req_ready=0, done=0, err=0, busy=0, pll_ready=0, sys_rst=1, phasesel=0, phasedir=1, phasestep=1; state WAIT_LOCK; lock counter 0.
- Lock synchroniser: two-flop chain on pll_locked (lock_s). Lock filter counter increments while lock_s=1 and clears while lock_s=0. pll_ready rises when the counter reaches LOCK_FILTER and stays set while lock_s=1. sys_rst = registered ~pll_ready (one-cycle lag).
- States: WAIT_LOCK, IDLE, SETUP, STEP_LO, STEP_HI, SETTLE.
  - WAIT_LOCK -> IDLE when pll_ready=1.
  - IDLE: req_ready = pll_ready. On accept, latch sel/dir/count, set busy.
    - count=0: go straight to IDLE; done pulses the cycle after accept; no pin activity.
    - count>0: go to SETUP; phasesel/phasedir update in the first SETUP cycle.
  - SETUP: hold for SETUP_CYCLES, then STEP_LO.
  - STEP_LO: phasestep=0 for STEP_LOW_CYCLES, then STEP_HI.
  - STEP_HI: phasestep=1 for STEP_HIGH_CYCLES. Decrement the remaining count on exit; go to STEP_LO if remaining ≠ 0, else SETTLE.
  - SETTLE: SETTLE_CYCLES, then IDLE with a done pulse.
- Latency: done is asserted exactly SETUP_CYCLES + N·(STEP_LOW_CYCLES+STEP_HIGH_CYCLES) + SETTLE_CYCLES + 1 cycles after the accept edge. With defaults and N=3 this is 43.
- req_ready is 0 in every state except IDLE, so there is no back-to-back accept in the done cycle. The next accept is possible one cycle after done.
- phasesel/phasedir hold their last values in IDLE. Pin changes occur only in SETUP.
- Lock loss: when lock_s falls in any state, the same cycle clears pll_ready and the filter, and the next cycle enters WAIT_LOCK.
  - Forced outputs: phasestep=1, busy=0, req_ready=0.
  - err pulses one cycle if busy was 1. done is not asserted.
  - Steps already issued are not retried.
- reset mid-operation returns every output to its reset value on the next edge, regardless of state.
- Counters are sized to their parameter (clog2). The remaining-count register is COUNT_W bits, with no wrap since decrement occurs only when nonzero.

Decomposition:
- Shared package: state encoding enum; output-select constants SEL_CLKOP..SEL_CLKOS3; DIR_ADVANCE=1/DIR_RETARD=0.
- One natural sub-module, pll_lock_filter: synchroniser + LOCK_FILTER counter producing pll_ready and sys_rst. The FSM and step timer stay in the top level.

Test Plan:
- Reset released, pll_locked high from cycle 0: pll_ready=1 and sys_rst=0 after 2+16 cycles (±1 for the registered stage). req_ready=1 in IDLE.
- pll_locked glitches low for 1 cycle at filter count 10: pll_ready stays 0; filter restarts; ready arrives 16 synced-high cycles after the glitch.
- Request sel=2, dir=1, count=3 (defaults): phasesel=2, phasedir=1; exactly 3 phasestep low pulses, 4 cycles each, spaced 4 high; done at accept+43; busy high throughout.
- Request count=0: done the cycle after accept; phasestep never leaves 1; phasesel unchanged.
- pll_locked drops during the second STEP_LO: phasestep=1 within 3 cycles; err pulses once; no done; state WAIT_LOCK; req_ready=0 until relock + filter.
- reset asserted in SETTLE: next cycle all outputs equal reset values; sys_rst=1.

Source files
------------

// File: rtl/pll_phase_sequencer_pkg.sv
// rtl/pll_phase_sequencer_pkg.sv - shared types and constants for the PLL phase sequencer
//
// Purpose: sequencer state encoding, PHASESEL output codes, PHASEDIR codes and a
//          small helper for sizing timers from the timing parameters.
// Ports:   none (package)

package pll_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    SETTLE
  } seqState_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam logic DIR_ADVANCE = 1'b1;
  localparam logic DIR_RETARD  = 1'b0;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_phase_sequencer_if.sv
// rtl/pll_phase_sequencer_if.sv - phase-shift request/status bundle
//
// Purpose: groups the requester handshake (valid/ready + sel/dir/count) and the
//          completion status (done/err/busy).
// Ports:   master = requester (calibration routine / register port),
//          slave  = pll_phase_sequencer.

interface pll_phase_sequencer_if #(
  parameter int COUNT_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_sel;
  logic               req_dir;
  logic [COUNT_W-1:0] req_count;
  logic               done;
  logic               err;
  logic               busy;

  modport master (
    output req_valid, req_sel, req_dir, req_count,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_count,
    output req_ready, done, err, busy
  );
endinterface

// File: rtl/pll_lock_filter.sv
// rtl/pll_lock_filter.sv - lock synchroniser and filter producing pll_ready/sys_rst
//
// Purpose: brings the asynchronous PLL LOCK into the reference clock domain and
//          declares the PLL ready after LOCK_FILTER consecutive synced-high cycles.
// Ports:   clock, reset      - reference clock, synchronous active-high reset
//          pllLocked         - raw PLL LOCK (asynchronous)
//          pllReady          - filtered lock; drops in the same cycle the synced lock drops
//          sysRst            - registered ~pllReady for downstream logic

module pll_lock_filter #(
  parameter int LOCK_FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pllLocked,
  output logic pllReady,
  output logic sysRst
);

  localparam int CNT_W = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0] FILTER_MAX = CNT_W'(LOCK_FILTER);

  logic             lockMeta;
  logic             lockS;
  logic [CNT_W-1:0] lockCnt;

  // Counter saturates at LOCK_FILTER; readiness is gated by lockS directly so a
  // lock loss removes pllReady without waiting for the counter to clear.
  assign pllReady = lockS && (lockCnt == FILTER_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      lockMeta <= 1'b0;
      lockS    <= 1'b0;
      lockCnt  <= '0;
      sysRst   <= 1'b1;
    end else begin
      lockMeta <= pllLocked;
      lockS    <= lockMeta;
      if (!lockS) begin
        lockCnt <= '0;
      end else if (lockCnt != FILTER_MAX) begin
        lockCnt <= lockCnt + 1'b1;
      end
      sysRst <= ~pllReady;
    end
  end

endmodule

// File: rtl/pll_phase_sequencer.sv
// rtl/pll_phase_sequencer.sv - PLL lock qualification and dynamic phase-step sequencer
//
// Purpose: qualifies PLL lock, generates the downstream synchronous reset, and
//          drives PHASESEL/PHASEDIR/PHASESTEP to apply N phase steps on request.
// Ports:   clock, reset            - 25 MHz reference clock, synchronous active-high reset
//          pll_locked              - raw PLL LOCK (asynchronous)
//          req (slave modport)     - request handshake and done/err/busy status
//          pll_ready, sys_rst      - filtered lock status and downstream reset
//          phasesel/phasedir/phasestep - to the PLL dynamic phase pins (phasestep idles high)

module pll_phase_sequencer
  import pll_phase_sequencer_pkg::*;
#(
  parameter int LOCK_FILTER      = 16,
  parameter int SETUP_CYCLES     = 2,
  parameter int STEP_LOW_CYCLES  = 4,
  parameter int STEP_HIGH_CYCLES = 4,
  parameter int SETTLE_CYCLES    = 16,
  parameter int COUNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_locked,
  pll_phase_sequencer_if.slave  req,
  output logic                  pll_ready,
  output logic                  sys_rst,
  output logic [1:0]            phasesel,
  output logic                  phasedir,
  output logic                  phasestep
);

  localparam int TIMER_MAX = maxOf(maxOf(SETUP_CYCLES, STEP_LOW_CYCLES),
                                   maxOf(STEP_HIGH_CYCLES, SETTLE_CYCLES));
  localparam int TIMER_W = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] SETUP_LAST  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LAST    = TIMER_W'(STEP_LOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HIGH_LAST   = TIMER_W'(STEP_HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

  seqState_t          state;
  logic [TIMER_W-1:0] timer;
  logic [COUNT_W-1:0] remaining;
  logic               reqReady;
  logic               doneQ;
  logic               errQ;
  logic               busyQ;

  assign req.req_ready = reqReady;
  assign req.done      = doneQ;
  assign req.err       = errQ;
  assign req.busy      = busyQ;

  pll_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clock     (clock),
    .reset     (reset),
    .pllLocked (pll_locked),
    .pllReady  (pll_ready),
    .sysRst    (sys_rst)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      timer     <= '0;
      remaining <= '0;
      reqReady  <= 1'b0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      busyQ     <= 1'b0;
      phasesel  <= SEL_CLKOP;
      phasedir  <= DIR_ADVANCE;
      phasestep <= 1'b1;
    end else begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
      if (state != WAIT_LOCK && !pll_ready) begin
        // Lock lost: abandon the request. busy is still high in the done cycle,
        // so a completed request is not reported as aborted.
        state     <= WAIT_LOCK;
        timer     <= '0;
        reqReady  <= 1'b0;
        busyQ     <= 1'b0;
        phasestep <= 1'b1;
        errQ      <= busyQ && !doneQ;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (pll_ready) begin
              state    <= IDLE;
              reqReady <= 1'b1;
            end
          end
          IDLE: begin
            if (doneQ) begin
              // Completion cycle: ready reopens only after done has been seen.
              busyQ    <= 1'b0;
              reqReady <= 1'b1;
            end else if (reqReady && req.req_valid) begin
              reqReady <= 1'b0;
              busyQ    <= 1'b1;
              if (req.req_count == '0) begin
                doneQ <= 1'b1;
              end else begin
                state     <= SETUP;
                timer     <= '0;
                phasesel  <= req.req_sel;
                phasedir  <= req.req_dir;
                remaining <= req.req_count;
              end
            end
          end
          SETUP: begin
            if (timer == SETUP_LAST) begin
              timer     <= '0;
              phasestep <= 1'b0;
              state     <= STEP_LO;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          STEP_LO: begin
            if (timer == LOW_LAST) begin
              timer     <= '0;
              phasestep <= 1'b1;
              state     <= STEP_HI;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          STEP_HI: begin
            if (timer == HIGH_LAST) begin
              timer     <= '0;
              remaining <= remaining - 1'b1;
              if (remaining != COUNT_W'(1)) begin
                phasestep <= 1'b0;
                state     <= STEP_LO;
              end else begin
                state <= SETTLE;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SETTLE: begin
            if (timer == SETTLE_LAST) begin
              timer <= '0;
              state <= IDLE;
              doneQ <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= WAIT_LOCK;
          end
        endcase
      end
    end
  end

endmodule
